// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier, W x W -> 2W, one step per clock.
// Datapath add/sub uses a parallel-prefix carry-lookahead adder.

module addsub_cla #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         m,
    output logic [W-1:0] s,
    output logic         v
);

    localparam int L = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0] bx;
    logic [W-1:0] g;
    logic [W-1:0] pr;
    logic [W-1:0] gl [0:L];
    logic [W-1:0] pl [0:L];
    logic [W:0]   c;

    // Kogge-Stone prefix tree: gl[L][i]/pl[L][i] span bits i..0
    always_comb begin
        bx    = b ^ {W{m}};
        g     = a & bx;
        pr    = a ^ bx;
        gl[0] = g;
        pl[0] = pr;
        for (int l = 1; l <= L; l++) begin
            for (int i = 0; i < W; i++) begin
                if (i >= (1 << (l - 1))) begin
                    gl[l][i] = gl[l-1][i]
                             | (pl[l-1][i] & gl[l-1][i-(1<<(l-1))]);
                    pl[l][i] = pl[l-1][i] & pl[l-1][i-(1<<(l-1))];
                end else begin
                    gl[l][i] = gl[l-1][i];
                    pl[l][i] = pl[l-1][i];
                end
            end
        end
        c[0] = m;
        for (int i = 0; i < W; i++) begin
            c[i+1] = gl[L][i] | (pl[L][i] & m);
        end
        s = pr ^ c[W-1:0];
        v = c[W] ^ c[W-1];
    end

endmodule

module booth_mul_seq #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  mc;
    logic [W-1:0]  acc;
    logic [W-1:0]  q;
    logic          q_1;
    logic [CW-1:0] cnt;

    logic [W-1:0]  s;
    logic          v;
    logic [W-1:0]  sum;
    logic          msb;
    logic [W-1:0]  acc_n;
    logic [W-1:0]  q_n;

    addsub_cla #(.W(W)) u_addsub (
        .a (acc),
        .b (mc),
        .m (q[0]),
        .s (s),
        .v (v)
    );

    // On add/sub the true sign is S^V, so ACC - (-2^(W-1)) stays exact
    always_comb begin
        sum = acc;
        msb = acc[W-1];
        unique case ({q[0], q_1})
            2'b01, 2'b10: begin
                sum = s;
                msb = s[W-1] ^ v;
            end
            default: begin
                sum = acc;
                msb = acc[W-1];
            end
        endcase
        acc_n = {msb, sum[W-1:1]};
        q_n   = {sum[0], q[W-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            mc    <= '0;
            acc   <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mc    <= x;
                        q     <= y;
                        acc   <= '0;
                        q_1   <= 1'b0;
                        cnt   <= CW'(W);
                        busy  <= 1'b1;
                        state <= S_CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc <= acc_n;
                    q   <= q_n;
                    q_1 <= q[0];
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        p     <= {acc_n, q_n};
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and exhaustive checks of booth_mul_seq at W=4 and W=8.
// Expected products come from hand tables and a signed integer model.

module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start4, start8;
    logic [3:0]  x4, y4;
    logic [7:0]  x8, y8;
    logic        busy4, done4, busy8, done8;
    logic [7:0]  p4;
    logic [15:0] p8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] p;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    booth_mul_seq #(.W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .x     (x4),
        .y     (y4),
        .busy  (busy4),
        .done  (done4),
        .p     (p4)
    );

    booth_mul_seq #(.W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .x     (x8),
        .y     (y8),
        .busy  (busy8),
        .done  (done8),
        .p     (p8)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op; n = negedges after the accepting edge until done
    task automatic go4(input logic [3:0] xa, input logic [3:0] ya,
                       output int n);
        @(negedge clk);
        x4 = xa;
        y4 = ya;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic go8(input logic [7:0] xa, input logic [7:0] ya,
                       output int n);
        @(negedge clk);
        x8 = xa;
        y8 = ya;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic logic [7:0] ref4(input logic [3:0] a,
                                        input logic [3:0] b);
        int pr;
        pr = int'($signed(a)) * int'($signed(b));
        return pr[7:0];
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a,
                                         input logic [7:0] b);
        int pr;
        pr = int'($signed(a)) * int'($signed(b));
        return pr[15:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bc, dn_at, dn_cnt;
        logic [7:0] cap;

        tbl[0] = '{4'h3, 4'h5, 8'h0F};
        tbl[1] = '{4'hD, 4'h5, 8'hF1};
        tbl[2] = '{4'h5, 4'hD, 8'hF1};
        tbl[3] = '{4'h8, 4'h8, 8'h40};
        tbl[4] = '{4'h7, 4'h8, 8'hC8};
        tbl[5] = '{4'h0, 4'hF, 8'h00};

        rst_n  = 1'b0;
        start4 = 1'b0;
        start8 = 1'b0;
        x4 = '0; y4 = '0; x8 = '0; y8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy4, 1'b0);
        chk("rst_done", done4, 1'b0);
        chk("rst_p", p4, 8'h00);
        chk("rst_p8", p8, 16'h0000);
        rst_n = 1'b1;

        // Latency and pulse shape of the first product
        @(negedge clk);
        x4 = 4'h3; y4 = 4'h5; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        bc = 0; dn_at = 0; dn_cnt = 0;
        for (int i = 1; i <= 7; i++) begin
            if (i > 1) @(negedge clk);
            if (busy4) bc++;
            if (done4) begin
                dn_cnt++;
                if (dn_at == 0) dn_at = i;
                cap = p4;
            end
        end
        chk("lat_busy_cycles", bc, 4);
        chk("lat_done_at", dn_at, 5);
        chk("lat_done_pulses", dn_cnt, 1);
        chk("lat_p", cap, 8'h0F);

        foreach (tbl[k]) begin
            go4(tbl[k].x, tbl[k].y, n);
            chk($sformatf("tbl%0d_lat", k), n, 5);
            chk($sformatf("tbl%0d_done", k), done4, 1'b1);
            chk($sformatf("tbl%0d_p", k), p4, tbl[k].p);
        end

        // START pulsed mid-CALC must be ignored
        @(negedge clk);
        x4 = 4'h7; y4 = 4'h8; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        x4 = 4'h1; y4 = 4'h1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        dn_cnt = 0;
        cap = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done4) begin
                dn_cnt++;
                cap = p4;
            end
        end
        chk("mid_done_pulses", dn_cnt, 1);
        chk("mid_p", cap, 8'hC8);

        // START held: back-to-back without an idle cycle
        @(negedge clk);
        x4 = 4'h3; y4 = 4'h5; start4 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done4 && n < 20);
        chk("b2b_done1", done4, 1'b1);
        chk("b2b_p1", p4, 8'h0F);
        x4 = 4'hD; y4 = 4'h5;
        @(negedge clk);
        chk("b2b_gap_busy", busy4, 1'b1);
        chk("b2b_gap_done", done4, 1'b0);
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_lat2", n, 5);
        chk("b2b_p2", p4, 8'hF1);

        // Asynchronous reset in the second CALC cycle
        @(negedge clk);
        x4 = 4'h3; y4 = 4'h5; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy4, 1'b0);
        chk("arst_done", done4, 1'b0);
        chk("arst_p", p4, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        go4(4'h8, 4'h8, n);
        chk("arst_next_lat", n, 5);
        chk("arst_next_p", p4, 8'h40);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                go4(4'(a), 4'(b), n);
                chk($sformatf("ex_%0d_%0d", a, b), {done4, p4},
                    {1'b1, ref4(4'(a), 4'(b))});
            end
        end

        go8(8'h80, 8'h80, n);
        chk("w8_lat", n, 9);
        chk("w8_minmin", p8, 16'h4000);
        go8(8'h7F, 8'h80, n);
        chk("w8_maxmin", p8, 16'hC080);
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            go8(ra, rb, n);
            chk($sformatf("w8_rnd_%0h_%0h", ra, rb), {done8, p8},
                {1'b1, ref8(ra, rb)});
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
